// File: rtl/fft_pkg.sv
// Shared FFT types: scheduler state encoding and the write-back delay-line entry.
// Address fields are sized for the largest supported transform (N_POINTS <= 2**FFT_MAX_AW).
package fft_pkg;

    localparam int FFT_MAX_AW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fft_sched_state_t;

    typedef struct packed {
        logic                  valid;
        logic [FFT_MAX_AW-1:0] addr_a;
        logic [FFT_MAX_AW-1:0] addr_b;
    } fft_wb_t;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} from issue to write-back.
// Latency BFLY_LAT cycles; no backpressure, one entry shifts per cycle; synchronous clear.
module fft_wb_delay
    import fft_pkg::*;
#(
    parameter int BFLY_LAT = 3
) (
    input  logic    i_clk,
    input  logic    i_clr,
    input  fft_wb_t i_wb,
    output fft_wb_t o_wb
);

    fft_wb_t r_pipe [BFLY_LAT];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int i = 0; i < BFLY_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= i_wb;
            for (int i = 1; i < BFLY_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_wb = r_pipe[BFLY_LAT-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// In-place radix-2 DIT FFT sequencer: one butterfly issue per cycle, write-back BFLY_LAT later.
// Latency L*(N/2+BFLY_LAT)+1 cycles start-to-done; no backpressure, datapath must accept every issue.
// Optional FFT_SCHED_IFFT_EN adds i_inverse (latched at start) and o_tw_conj.
module fft_bfly_sched
    import fft_pkg::*;
#(
    parameter  int N_POINTS = 64,
    parameter  int BFLY_LAT = 3,
    localparam int L        = $clog2(N_POINTS),
    localparam int AW       = L,
    localparam int SW       = $clog2(L)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
`ifdef FFT_SCHED_IFFT_EN
    input  logic          i_inverse,
    output logic          o_tw_conj,
`endif
    output logic          o_busy,
    output logic          o_done,
    output logic [SW-1:0] o_stage,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr_a,
    output logic [AW-1:0] o_rd_addr_b,
    output logic [AW-2:0] o_tw_idx,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr_a,
    output logic [AW-1:0] o_wr_addr_b
);

    localparam int KW = L - 1;
    localparam int DW = $clog2(BFLY_LAT + 1);

    fft_sched_state_t r_state;
    logic [KW-1:0]    r_k;
    logic [SW-1:0]    r_stage;
    logic [DW-1:0]    r_drain;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [AW-1:0]    r_rd_addr_a;
    logic [AW-1:0]    r_rd_addr_b;
    logic [AW-2:0]    r_tw_idx;
`ifdef FFT_SCHED_IFFT_EN
    logic             r_tw_conj;
`endif

    logic [AW-1:0] w_k;
    logic [AW-1:0] w_half;
    logic [AW-1:0] w_pos;
    logic [AW-1:0] w_addr_a;
    logic [AW-1:0] w_addr_b;
    logic [AW-1:0] w_tw;
    logic          w_last_k;
    logic          w_last_stage;
    logic          w_last_drain;

    // Group base is k with its low s bits cleared and shifted up one: grp*2*half.
    always_comb begin
        w_k      = AW'(r_k);
        w_half   = AW'(1) << r_stage;
        w_pos    = w_k & (w_half - AW'(1));
        w_addr_a = (((w_k >> r_stage) << 1) << r_stage) | w_pos;
        w_addr_b = w_addr_a + w_half;
        w_tw     = w_pos << (AW'(L - 1) - AW'(r_stage));
    end

    assign w_last_k     = (r_k == KW'(N_POINTS / 2 - 1));
    assign w_last_stage = (r_stage == SW'(L - 1));
    assign w_last_drain = (r_drain == DW'(BFLY_LAT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_stage     <= '0;
            r_drain     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_idx    <= '0;
`ifdef FFT_SCHED_IFFT_EN
            r_tw_conj   <= 1'b0;
`endif
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                        r_stage <= '0;
                        r_drain <= '0;
`ifdef FFT_SCHED_IFFT_EN
                        r_tw_conj <= i_inverse;
`endif
                    end
                end
                ST_RUN: begin
                    r_rd_en     <= 1'b1;
                    r_rd_addr_a <= w_addr_a;
                    r_rd_addr_b <= w_addr_b;
                    r_tw_idx    <= w_tw[AW-2:0];
                    r_k         <= r_k + KW'(1);
                    if (w_last_k) begin
                        r_k     <= '0;
                        r_drain <= '0;
                        r_state <= ST_DRAIN;
                    end
                end
                // Hold off the next stage until the last write-back of this one has issued.
                ST_DRAIN: begin
                    r_drain <= r_drain + DW'(1);
                    if (w_last_drain) begin
                        r_drain <= '0;
                        if (w_last_stage) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_stage <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    fft_wb_t w_wb_in;
    fft_wb_t w_wb_out;
    logic    w_unused;

    always_comb begin
        w_wb_in        = '0;
        w_wb_in.valid  = r_rd_en;
        w_wb_in.addr_a = FFT_MAX_AW'(r_rd_addr_a);
        w_wb_in.addr_b = FFT_MAX_AW'(r_rd_addr_b);
    end

    fft_wb_delay #(
        .BFLY_LAT (BFLY_LAT)
    ) u_wb_delay (
        .i_clk (i_clk),
        .i_clr (i_rst),
        .i_wb  (w_wb_in),
        .o_wb  (w_wb_out)
    );

    assign w_unused    = |{w_wb_out.addr_a >> AW, w_wb_out.addr_b >> AW};

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_stage     = r_stage;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_addr_a;
    assign o_rd_addr_b = r_rd_addr_b;
    assign o_tw_idx    = r_tw_idx;
    assign o_wr_en     = w_wb_out.valid;
    assign o_wr_addr_a = AW'(w_wb_out.addr_a);
    assign o_wr_addr_b = AW'(w_wb_out.addr_b);
`ifdef FFT_SCHED_IFFT_EN
    assign o_tw_conj   = r_tw_conj;
`endif

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Bench for fft_bfly_sched: three instances (N=8/LAT=3, N=64/LAT=1, N=64/LAT=5) checked
// cycle by cycle against a per-stage butterfly table built from the transform definition.
module tb_fft_bfly_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] st;
    always #5 clk = ~clk;

    logic       busy8, done8, rd8, wr8;
    logic [1:0] stage8, tw8;
    logic [2:0] ra8, rb8, wa8, wb8;
    logic       busyA, doneA, rdA, wrA, busyB, doneB, rdB, wrB;
    logic [2:0] stageA, stageB;
    logic [4:0] twA, twB;
    logic [5:0] raA, rbA, waA, wbA, raB, rbB, waB, wbB;
`ifdef FFT_SCHED_IFFT_EN
    logic inv8, invA, invB, conj8, conjA, conjB;
`endif

    fft_bfly_sched #(.N_POINTS(8), .BFLY_LAT(3)) u8 (
        .i_clk(clk), .i_rst(rst), .i_start(st[0]),
`ifdef FFT_SCHED_IFFT_EN
        .i_inverse(inv8), .o_tw_conj(conj8),
`endif
        .o_busy(busy8), .o_done(done8), .o_stage(stage8), .o_rd_en(rd8),
        .o_rd_addr_a(ra8), .o_rd_addr_b(rb8), .o_tw_idx(tw8),
        .o_wr_en(wr8), .o_wr_addr_a(wa8), .o_wr_addr_b(wb8));

    fft_bfly_sched #(.N_POINTS(64), .BFLY_LAT(1)) u64a (
        .i_clk(clk), .i_rst(rst), .i_start(st[1]),
`ifdef FFT_SCHED_IFFT_EN
        .i_inverse(invA), .o_tw_conj(conjA),
`endif
        .o_busy(busyA), .o_done(doneA), .o_stage(stageA), .o_rd_en(rdA),
        .o_rd_addr_a(raA), .o_rd_addr_b(rbA), .o_tw_idx(twA),
        .o_wr_en(wrA), .o_wr_addr_a(waA), .o_wr_addr_b(wbA));

    fft_bfly_sched #(.N_POINTS(64), .BFLY_LAT(5)) u64b (
        .i_clk(clk), .i_rst(rst), .i_start(st[2]),
`ifdef FFT_SCHED_IFFT_EN
        .i_inverse(invB), .o_tw_conj(conjB),
`endif
        .o_busy(busyB), .o_done(doneB), .o_stage(stageB), .o_rd_en(rdB),
        .o_rd_addr_a(raB), .o_rd_addr_b(rbB), .o_tw_idx(twB),
        .o_wr_en(wrB), .o_wr_addr_a(waB), .o_wr_addr_b(wbB));

    // Monitor view of the instance currently under test, widened to the largest size.
    int         mon_sel;
    logic       m_busy, m_done, m_rd, m_wr;
    logic [2:0] m_st;
    logic [4:0] m_tw;
    logic [5:0] m_ra, m_rb, m_wa, m_wb;

    always_comb begin
        m_busy = busy8; m_done = done8; m_rd = rd8; m_wr = wr8;
        m_st = 3'(stage8); m_tw = 5'(tw8);
        m_ra = 6'(ra8); m_rb = 6'(rb8); m_wa = 6'(wa8); m_wb = 6'(wb8);
        if (mon_sel == 1) begin
            m_busy = busyA; m_done = doneA; m_rd = rdA; m_wr = wrA; m_st = stageA; m_tw = twA;
            m_ra = raA; m_rb = rbA; m_wa = waA; m_wb = wbA;
        end else if (mon_sel == 2) begin
            m_busy = busyB; m_done = doneB; m_rd = rdB; m_wr = wrB; m_st = stageB; m_tw = twB;
            m_ra = raB; m_rb = rbB; m_wa = waB; m_wb = wbB;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected behaviour indexed by cycle offset from the accepting edge.
    bit e_rv [512];
    bit e_wv [512];
    bit e_done [512];
    bit e_busy [512];
    int e_ra [512];
    int e_rb [512];
    int e_tw [512];
    int e_st [512];
    int e_wa [512];
    int e_wb [512];

    function automatic void clear_model();
        for (int i = 0; i < 512; i++) begin
            e_rv[i] = 0; e_wv[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_ra[i] = 0; e_rb[i] = 0; e_tw[i] = 0; e_st[i] = 0; e_wa[i] = 0; e_wb[i] = 0;
        end
    endfunction

    // Textbook DIT loop nest: for each stage, each group, each position in the group.
    function automatic void build(input int n, input int lat, input int base);
        int l, per, half, k, off, a, b, dn;
        l   = $clog2(n);
        per = n / 2 + lat;
        for (int s = 0; s < l; s++) begin
            half = 1 << s;
            k    = 0;
            for (int g = 0; g < n / (2 * half); g++) begin
                for (int p = 0; p < half; p++) begin
                    off = base + 1 + s * per + k;
                    a   = g * 2 * half + p;
                    b   = a + half;
                    e_rv[off] = 1; e_ra[off] = a; e_rb[off] = b;
                    e_tw[off] = p * (n / (2 * half)); e_st[off] = s;
                    e_wv[off + lat] = 1; e_wa[off + lat] = a; e_wb[off + lat] = b;
                    k++;
                end
            end
        end
        dn = base + l * per + 1;
        e_done[dn] = 1;
        for (int o = base; o < dn; o++) e_busy[o] = 1;
    endfunction

    // mode 0: single start pulse; 1: extra start pulses mid-run and in DONE; 2: start held high.
    task automatic run_check(input int sel, input int n, input int lat, input int mode, input int span);
        int per, p1, p2, l;
        l   = $clog2(n);
        per = n / 2 + lat;
        clear_model();
        build(n, lat, 0);
        if (mode == 2) build(n, lat, l * per + 2);
        p1 = $urandom_range(1, 20);
        p2 = $urandom_range(1, 20);
        mon_sel = sel;
        st[sel] = 1'b1;
        @(negedge clk);
        for (int off = 0; off <= span; off++) begin
            n_checks += 4;
            if (m_rd !== e_rv[off]) begin
                n_fail++; $display("FAIL rd_en sel%0d mode%0d off%0d got %b want %b", sel, mode, off, m_rd, e_rv[off]);
            end
            if (m_wr !== e_wv[off]) begin
                n_fail++; $display("FAIL wr_en sel%0d mode%0d off%0d got %b want %b", sel, mode, off, m_wr, e_wv[off]);
            end
            if (m_done !== e_done[off]) begin
                n_fail++; $display("FAIL done sel%0d mode%0d off%0d got %b want %b", sel, mode, off, m_done, e_done[off]);
            end
            if (m_busy !== e_busy[off]) begin
                n_fail++; $display("FAIL busy sel%0d mode%0d off%0d got %b want %b", sel, mode, off, m_busy, e_busy[off]);
            end
            if (e_rv[off]) begin
                n_checks++;
                if (int'(m_ra) !== e_ra[off] || int'(m_rb) !== e_rb[off] ||
                    int'(m_tw) !== e_tw[off] || int'(m_st) !== e_st[off]) begin
                    n_fail++;
                    $display("FAIL issue sel%0d off%0d got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                             sel, off, m_ra, m_rb, m_tw, m_st, e_ra[off], e_rb[off], e_tw[off], e_st[off]);
                end
            end
            if (e_wv[off]) begin
                n_checks++;
                if (int'(m_wa) !== e_wa[off] || int'(m_wb) !== e_wb[off]) begin
                    n_fail++;
                    $display("FAIL writeback sel%0d off%0d got a=%0d b=%0d want a=%0d b=%0d",
                             sel, off, m_wa, m_wb, e_wa[off], e_wb[off]);
                end
            end
            case (mode)
                1:       st[sel] = (off == p1 || off == p2 || off == l * per);
                2:       st[sel] = (off < 30);
                default: st[sel] = 1'b0;
            endcase
            @(negedge clk);
        end
        st[sel] = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        for (int s = 0; s < 3; s++) begin
            mon_sel = s;
            #1;
            n_checks++;
            if ({m_busy, m_done, m_rd, m_wr, m_st, m_tw, m_ra, m_rb, m_wa, m_wb} !== '0) begin
                n_fail++;
                $display("FAIL %s sel%0d got busy=%b done=%b rd=%b wr=%b st=%0d tw=%0d ra=%0d rb=%0d wa=%0d wb=%0d want all 0",
                         tag, s, m_busy, m_done, m_rd, m_wr, m_st, m_tw, m_ra, m_rb, m_wa, m_wb);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        st  = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_stage_walk();
        run_check(0, 8, 3, 0, 30);
    endtask

    task automatic test_start_ignored();
        run_check(0, 8, 3, 1, 30);
    endtask

    task automatic test_start_held();
        run_check(0, 8, 3, 2, 52);
    endtask

    task automatic test_reset_midrun();
        mon_sel = 0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rd8 !== 1'b1 || stage8 !== 2'd1 || ra8 !== 3'd4 || rb8 !== 3'd6) begin
            n_fail++;
            $display("FAIL pre_abort_issue got rd=%b st=%0d a=%0d b=%0d want rd=1 st=1 a=4 b=6", rd8, stage8, ra8, rb8);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("abort_outputs");
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (wr8 !== 1'b0 || busy8 !== 1'b0 || rd8 !== 1'b0) begin
                n_fail++; $display("FAIL post_abort_quiet cyc%0d got wr=%b busy=%b rd=%b want 0", i, wr8, busy8, rd8);
            end
            @(negedge clk);
        end
        run_check(0, 8, 3, 0, 30);
    endtask

    task automatic test_n64();
        run_check(1, 64, 1, 0, 210);
        run_check(2, 64, 5, 0, 235);
    endtask

`ifdef FFT_SCHED_IFFT_EN
    task automatic test_ifft();
        int want;
        for (int rep = 0; rep < 2; rep++) begin
            want = (rep == 0) ? 1 : int'($urandom_range(0, 1));
            inv8 = want[0];
            st[0] = 1'b1;
            @(negedge clk);
            st[0] = 1'b0;
            for (int off = 0; off < 25; off++) begin
                if (off == 6) inv8 = ~inv8;
                if (rd8) begin
                    n_checks++;
                    if (conj8 !== want[0]) begin
                        n_fail++; $display("FAIL tw_conj off%0d got %b want %b", off, conj8, want[0]);
                    end
                end
                @(negedge clk);
            end
            repeat (2) @(negedge clk);
        end
    endtask
`endif

    initial begin
        st      = '0;
        rst     = 1'b1;
        mon_sel = 0;
`ifdef FFT_SCHED_IFFT_EN
        inv8 = 1'b0; invA = 1'b0; invB = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_stage_walk();
        test_start_ignored();
        test_start_held();
        test_reset_midrun();
        test_n64();
`ifdef FFT_SCHED_IFFT_EN
        test_ifft();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
